led_p2s: RTL and testbench

- Parallel-to-serial transmitter for the board's shift-register LED chain.
- Latches a WIDTH-bit LED pattern on a start request and clocks it out MSB first on LEDDT/LEDCLK at a divided rate, then pulses LEDEN to latch the chain.
- Sits at the top level beside the debounced switch/key input path and owns the LEDCLK, LEDDT, LEDCLR and LEDEN board pins.

---
 rtl/led_p2s_pkg.sv | 18 +
 rtl/led_p2s_tick.sv | 42 ++++
 rtl/led_p2s.sv | 141 ++++++++++++++
 tb/tb_led_p2s.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_p2s_pkg.sv
// led_p2s_pkg
// Shared definitions for the LED chain parallel-to-serial transmitter:
//   - led_p2s_state_e : transmitter FSM states
//   - LED_P2S_WIDTH   : default frame width (bits per frame)
//   - LED_P2S_CLK_DIV : default clk cycles per LEDCLK half-period
package led_p2s_pkg;

  localparam int LED_P2S_WIDTH   = 16;
  localparam int LED_P2S_CLK_DIV = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_p2s_state_e;

endpackage

// File: rtl/led_p2s_tick.sv
// led_p2s_tick
// Half-period counter for the LED shift clock. Counts 0..CLK_DIV-1 while
// enabled and wraps to 0 on the last count, flagging that cycle with
// phase_end.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   clr       synchronous clear (holds the count at 0)
//   en        count enable
//   phase_end one-cycle flag, high while enabled and count == CLK_DIV-1
module led_p2s_tick
  import led_p2s_pkg::*;
#(
  parameter int CLK_DIV = LED_P2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (phase_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_p2s.sv
// led_p2s
// Parallel-to-serial transmitter for the board's shift-register LED chain.
// On an accepted start the WIDTH-bit pattern is captured and shifted out
// MSB first on LEDDT, one bit per LEDCLK period (CLK_DIV cycles low, then
// CLK_DIV cycles high), followed by a CLK_DIV-cycle LEDEN latch strobe and
// a one-cycle done pulse.
// Build option:
//   LED_P2S_INVERT_EN  when defined, the captured pattern is inverted so
//                      LEDDT carries ~data (active-low LEDs).
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   start   frame request, sampled only while idle
//   data    LED pattern, captured on the accepted start
//   busy    high while a frame is in progress
//   done    one-cycle pulse at frame completion
//   LEDCLK  shift clock, chain samples LEDDT on its rising edge
//   LEDDT   serial data, MSB first
//   LEDCLR  active-low chain clear (low only during reset)
//   LEDEN   active-high latch strobe
module led_p2s
  import led_p2s_pkg::*;
#(
  parameter int WIDTH   = LED_P2S_WIDTH,
  parameter int CLK_DIV = LED_P2S_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             LEDCLK,
  output logic             LEDDT,
  output logic             LEDCLR,
  output logic             LEDEN
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  led_p2s_state_e state, next_state;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] cap;
  logic [IW-1:0]    idx;
  logic             phase_end;
  logic             accept;
  logic             advance;

`ifdef LED_P2S_INVERT_EN
  assign cap = ~data;
`else
  assign cap = data;
`endif

  // The register shifts left so the next bit is always at the MSB; this
  // avoids a variable index and stays legal for WIDTH=1.
  assign shreg_next = shreg << 1;

  led_p2s_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .en        (state != IDLE),
    .phase_end (phase_end)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) next_state = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (idx == '0) begin
            next_state = LATCH;
          end else begin
            advance    = 1'b1;
            next_state = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (phase_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are decoded from next_state and registered, so each pin changes
  // in the same cycle the FSM enters the corresponding phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      LEDCLK <= 1'b0;
      LEDDT  <= 1'b0;
      LEDCLR <= 1'b0;
      LEDEN  <= 1'b0;
    end else begin
      LEDCLR <= 1'b1;
      LEDCLK <= (next_state == SHIFT_HI);
      LEDEN  <= (next_state == LATCH);
      busy   <= (next_state != IDLE);
      done   <= (state == LATCH) && phase_end;
      if (accept) begin
        shreg <= cap;
        idx   <= TOP_IDX;
        LEDDT <= cap[WIDTH-1];
      end else if (advance) begin
        shreg <= shreg_next;
        idx   <= idx - IW'(1);
        LEDDT <= shreg_next[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_led_p2s.sv
// tb_led_p2s
// Drives three transmitter instances (16x8, 16x1, 1x2) with directed and
// random start/data/reset stimulus and compares every output, every cycle,
// against a frame-timing model computed from the start cycle and offsets.
module tb_led_p2s;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] st;
  logic [15:0]  dt [N];
  logic [N-1:0] busy, done, lclk, ldt, lclr, len;

  always #5 clk = ~clk;

  led_p2s #(.WIDTH(16), .CLK_DIV(8)) u_d0 (
    .clk(clk), .rst(rst), .start(st[0]), .data(dt[0]),
    .busy(busy[0]), .done(done[0]), .LEDCLK(lclk[0]), .LEDDT(ldt[0]),
    .LEDCLR(lclr[0]), .LEDEN(len[0]));

  led_p2s #(.WIDTH(16), .CLK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st[1]), .data(dt[1]),
    .busy(busy[1]), .done(done[1]), .LEDCLK(lclk[1]), .LEDDT(ldt[1]),
    .LEDCLR(lclr[1]), .LEDEN(len[1]));

  led_p2s #(.WIDTH(1), .CLK_DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .start(st[2]), .data(dt[2][0]),
    .busy(busy[2]), .done(done[2]), .LEDCLK(lclk[2]), .LEDDT(ldt[2]),
    .LEDCLR(lclr[2]), .LEDEN(len[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one frame record per instance
  int          act [N];
  int          t0  [N];
  logic [15:0] fd  [N];
  int          cyc   = 0;
  logic        rlast = 1'b1;

  function automatic int wof(int i);
    return (i == 2) ? 1 : 16;
  endfunction

  function automatic int cdof(int i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 2);
  endfunction

  function automatic int flen(int i);
    return (2 * wof(i) + 1) * cdof(i);
  endfunction

  function automatic logic bitv(int i, int j);
    logic b;
    b = fd[i][j];
`ifdef LED_P2S_INVERT_EN
    b = ~b;
`endif
    return b;
  endfunction

  // Expected {busy, done, LEDCLK, LEDDT, LEDCLR, LEDEN} in cycle x
  function automatic logic [5:0] expv(int i, int x, logic r);
    int o, p, w, cd, l;
    logic b, d, ck, dv, en;
    if (r) return 6'b0;
    w = wof(i); cd = cdof(i); l = flen(i);
    b = 1'b0; d = 1'b0; ck = 1'b0; dv = 1'b0; en = 1'b0;
    o = x - t0[i];
    if (act[i] != 0) begin
      if (o >= 1 && o <= l) begin
        b = 1'b1;
        p = (o - 1) / cd;
        if (p < 2 * w) begin
          ck = (p % 2) == 1;
          dv = bitv(i, w - 1 - p / 2);
        end else begin
          en = 1'b1;
          dv = bitv(i, 0);
        end
      end else begin
        dv = bitv(i, 0);
        d  = (o == l + 1);
      end
    end
    return {b, d, ck, dv, 1'b1, en};
  endfunction

  function automatic bit model_idle(int i);
    return (act[i] == 0) || ((cyc - t0[i]) >= flen(i) + 1);
  endfunction

  // Directed-frame monitors
  bit          mon_on = 0;
  logic [15:0] word0, word1;
  int          rises0, rises1, busy0, busy1, done0, en0;
  logic        pclk0, pclk1;

  // Apply inputs for the current cycle, advance the model, then check the
  // outputs of the following cycle at the falling edge.
  task automatic step(input logic r);
    rst = r;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        act[i] = 0;
      end else if (st[i] && model_idle(i)) begin
        act[i] = 1;
        t0[i]  = cyc;
        fd[i]  = dt[i];
      end
    end
    rlast = r;
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d_outs@%0d", i, cyc),
            {26'b0, busy[i], done[i], lclk[i], ldt[i], lclr[i], len[i]},
            {26'b0, expv(i, cyc, rlast)});
    end
    if (mon_on) begin
      if (lclk[0] && !pclk0) begin rises0++; word0 = {word0[14:0], ldt[0]}; end
      if (lclk[1] && !pclk1) begin rises1++; word1 = {word1[14:0], ldt[1]}; end
      busy0 += int'(busy[0]);
      busy1 += int'(busy[1]);
      done0 += int'(done[0]);
      en0   += int'(len[0]);
    end
    pclk0 = lclk[0];
    pclk1 = lclk[1];
  endtask

  initial begin
    int nres;
    logic [15:0] exp0, exp1;
    logic r;
    for (int i = 0; i < N; i++) begin
      act[i] = 0; t0[i] = 0; fd[i] = '0; dt[i] = '0;
    end
    st = '0;
    rst = 1'b1;
    pclk0 = 1'b0; pclk1 = 1'b0;

    // Reset held for 3 cycles, then idle with no start
    repeat (3) step(1'b1);
    repeat (4) step(1'b0);

    // Directed frames: A5C3 on d0, FFFF on d1; ignored start with stale data
    word0 = '0; word1 = '0;
    rises0 = 0; rises1 = 0; busy0 = 0; busy1 = 0; done0 = 0; en0 = 0;
    mon_on = 1;
    st[0] = 1'b1; dt[0] = 16'hA5C3;
    st[1] = 1'b1; dt[1] = 16'hFFFF;
    step(1'b0);
    st[0] = 1'b0; st[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      st[0] = (c == 100) || (c == 200);
      dt[0] = 16'h0000;
      st[2] = ($urandom_range(0, 3) == 0);
      dt[2] = 16'($urandom);
      step(1'b0);
    end
    mon_on = 0;
`ifdef LED_P2S_INVERT_EN
    exp0 = ~16'hA5C3;
    exp1 = 16'h0000;
`else
    exp0 = 16'hA5C3;
    exp1 = 16'hFFFF;
`endif
    check("d0_rises", rises0, 16);
    check("d0_bits",  word0,  exp0);
    check("d0_busy_cycles", busy0, 264);
    check("d0_done_count",  done0, 1);
    check("d0_en_cycles",   en0,   8);
    check("d1_rises", rises1, 16);
    check("d1_bits",  word1,  exp1);
    check("d1_busy_cycles", busy1, 33);

    // Start held high: back-to-back frames with data changing every cycle
    st = '1;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) dt[i] = 16'($urandom);
      step(1'b0);
    end

    // Random traffic with mid-frame resets (d0 at bit 5) and rare random resets
    nres = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        dt[i] = 16'($urandom);
      end
      r = ($urandom_range(0, 499) == 0);
      if (act[0] != 0 && (cyc - t0[0]) == 1 + 8 * 10 + 2 && nres < 3) begin
        r = 1'b1;
        nres++;
      end
      step(r);
    end
    check("mid_frame_resets", nres, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
